// File: rtl/video_tile_sampler.sv
// ---------------------------------------------------------------------------
// video_tile_sampler
//
// Reduces an active camera pixel stream to a TILE_W x TILE_H grid of
// quantised cells and publishes the complete grid once per frame. Cells are
// either point-sampled (top-left pixel of each cell) or box-averaged over the
// 2^CELL_SHIFT x 2^CELL_SHIFT cell. A frame whose last cell was never written
// is dropped rather than published, so consumers only ever see whole grids.
//
// Ports
//   clk             pixel clock, the only clock
//   reset           synchronous, active-high
//   in_frame        high during the active frame
//   in_href         line valid; one pixel per clk while high
//   in_data         pixel luminance
//   cfg_mode        0 = point sample, 1 = box average
//   cfg_threshold   binarisation threshold (OUT_BITS == 1 only)
//   cfg_origin_x/y  grid top-left corner in pixels / lines
//   out_cells       published grid, cell (r,c) at bit (r*TILE_W+c)*OUT_BITS
//   out_valid       one-cycle pulse when out_cells updates
//   out_drop        one-cycle pulse when an incomplete frame is discarded
//   out_frame_count number of published frames, wraps
// ---------------------------------------------------------------------------
module video_tile_sampler #(
  parameter int DATA_WIDTH = 10,
  parameter int X_BITS     = 11,
  parameter int Y_BITS     = 10,
  parameter int TILE_W     = 28,
  parameter int TILE_H     = 28,
  parameter int CELL_SHIFT = 4,
  parameter int OUT_BITS   = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_frame,
  input  logic                                in_href,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                cfg_mode,
  input  logic [DATA_WIDTH-1:0]               cfg_threshold,
  input  logic [X_BITS-1:0]                   cfg_origin_x,
  input  logic [Y_BITS-1:0]                   cfg_origin_y,
  output logic [TILE_W*TILE_H*OUT_BITS-1:0]   out_cells,
  output logic                                out_valid,
  output logic                                out_drop,
  output logic [15:0]                         out_frame_count
);

  localparam int GRID_BITS = TILE_W * TILE_H * OUT_BITS;
  localparam int ACC_W     = DATA_WIDTH + 2 * CELL_SHIFT;
  localparam int COL_W     = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int ROW_W     = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [X_BITS-1:0] X_MASK = X_BITS'((1 << CELL_SHIFT) - 1);
  localparam logic [Y_BITS-1:0] Y_MASK = Y_BITS'((1 << CELL_SHIFT) - 1);

  // Registered inputs: edges are seen one clk after the input transition.
  logic                  frame_q1, frame_q2;
  logic                  href_q1, href_q2;
  logic [DATA_WIDTH-1:0] data_q1;

  // Per-frame state and shadowed configuration.
  logic                  armed_q, row_done_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [X_BITS-1:0]     ox_q;
  logic [Y_BITS-1:0]     oy_q;
  logic [X_BITS-1:0]     x_q;
  logic [Y_BITS-1:0]     y_q;
  logic [ACC_W-1:0]      acc_q [TILE_W];

  // Quantise -> write pipeline stage.
  logic                  wr_en_q;
  logic [ROW_W-1:0]      wr_row_q;
  logic [COL_W-1:0]      wr_col_q;
  logic [OUT_BITS-1:0]   wr_cell_q;

  // Grids and frame-end sequencing.
  logic [GRID_BITS-1:0]  work_q, cells_q;
  logic                  pub_q, drp_q, valid_q, drop_q;
  logic [15:0]           count_q;

  logic                  frame_rise, frame_fall, href_fall, pix_ok;
  logic [X_BITS-1:0]     rx, col_full;
  logic [Y_BITS-1:0]     ry, row_full;
  logic                  in_win, take, lo_zero, lo_ones;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [ACC_W-1:0]      acc_sum;
  logic [DATA_WIDTH-1:0] avg_val, sample_val;
  logic [OUT_BITS-1:0]   cell_d;
  logic                  wr_last, grid_done;

  assign frame_rise = frame_q1 & ~frame_q2;
  assign frame_fall = ~frame_q1 & frame_q2;
  assign href_fall  = href_q2 & ~href_q1;
  assign pix_ok     = armed_q & frame_q1 & href_q1;

  // Window position relative to the shadowed origin; the subtraction is
  // meaningless (wraps) unless x >= origin, which in_win also requires.
  assign rx       = x_q - ox_q;
  assign ry       = y_q - oy_q;
  assign col_full = rx >> CELL_SHIFT;
  assign row_full = ry >> CELL_SHIFT;
  assign col      = col_full[COL_W-1:0];
  assign row      = row_full[ROW_W-1:0];
  assign in_win   = pix_ok && (x_q >= ox_q) && (y_q >= oy_q) &&
                    (col_full < X_BITS'(TILE_W)) && (row_full < Y_BITS'(TILE_H));
  assign lo_zero  = ((rx & X_MASK) == '0) && ((ry & Y_MASK) == '0);
  assign lo_ones  = ((rx & X_MASK) == X_MASK) && ((ry & Y_MASK) == Y_MASK);

  // The accumulator cannot overflow: at most 2^(2*CELL_SHIFT) pixels of
  // DATA_WIDTH bits each are summed before it clears.
  assign acc_sum    = acc_q[col] + ACC_W'(data_q1);
  assign avg_val    = DATA_WIDTH'(acc_sum >> (2 * CELL_SHIFT));
  assign sample_val = mode_q ? avg_val : data_q1;
  assign take       = in_win && (mode_q ? lo_ones : lo_zero);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cell_d = '0;
    if (OUT_BITS == 1) begin
      cell_d[0] = (sample_val > thr_q);
    end else begin
      cell_d = sample_val[DATA_WIDTH-1 -: OUT_BITS];
    end
  end

  // A write of the final cell landing in the same cycle as the frame-end
  // decision still counts, so a tight frame end is not spuriously dropped.
  assign wr_last   = wr_en_q && (wr_row_q == ROW_W'(TILE_H - 1)) &&
                     (wr_col_q == COL_W'(TILE_W - 1));
  assign grid_done = row_done_q | wr_last;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Edge registers follow the live input during reset so that a frame
      // already in progress is not mistaken for a fresh rising edge.
      frame_q1   <= in_frame;
      frame_q2   <= in_frame;
      href_q1    <= 1'b0;
      href_q2    <= 1'b0;
      data_q1    <= '0;
      armed_q    <= 1'b0;
      row_done_q <= 1'b0;
      mode_q     <= 1'b0;
      thr_q      <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      // NOTE: the accumulator and working-grid storage is reset explicitly
      // because a stale partial sum or cell must never leak into a frame.
      for (int i = 0; i < TILE_W; i++) acc_q[i] <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_cell_q  <= '0;
      work_q     <= '0;
      cells_q    <= '0;
      pub_q      <= 1'b0;
      drp_q      <= 1'b0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      frame_q1 <= in_frame;
      frame_q2 <= frame_q1;
      href_q1  <= in_href;
      href_q2  <= href_q1;
      data_q1  <= in_data;

      if (frame_rise) begin
        armed_q <= 1'b1;
        mode_q  <= cfg_mode;
        thr_q   <= cfg_threshold;
        ox_q    <= cfg_origin_x;
        oy_q    <= cfg_origin_y;
      end else if (frame_fall) begin
        armed_q <= 1'b0;
      end

      // Saturating coordinate counters.
      if (!href_q1)         x_q <= '0;
      else if (x_q != '1)   x_q <= x_q + X_BITS'(1);
      if (!frame_q1)                    y_q <= '0;
      else if (href_fall && y_q != '1)  y_q <= y_q + Y_BITS'(1);

      if (frame_rise) begin
        for (int i = 0; i < TILE_W; i++) acc_q[i] <= '0;
      end else if (in_win && mode_q) begin
        acc_q[col] <= take ? '0 : acc_sum;
      end

      // Stage 1: quantised cell; stage 2: working-grid write.
      wr_en_q   <= take;
      wr_row_q  <= row;
      wr_col_q  <= col;
      wr_cell_q <= cell_d;
      if (wr_en_q) begin
        work_q[(int'(wr_row_q) * TILE_W + int'(wr_col_q)) * OUT_BITS +: OUT_BITS] <= wr_cell_q;
      end

      if (frame_rise || frame_fall) row_done_q <= 1'b0;
      else if (wr_last)             row_done_q <= 1'b1;

      // Frame end: decide now, copy one clk later after the last write lands.
      pub_q   <= frame_fall & armed_q & grid_done;
      drp_q   <= frame_fall & armed_q & ~grid_done;
      valid_q <= pub_q;
      drop_q  <= drp_q;
      if (pub_q) begin
        cells_q <= work_q;
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign out_cells       = cells_q;
  assign out_valid       = valid_q;
  assign out_drop        = drop_q;
  assign out_frame_count = count_q;

endmodule

// File: tb/tb_video_tile_sampler.sv
// ---------------------------------------------------------------------------
// tb_video_tile_sampler
//
// Drives a 32x24 image into two samplers (OUT_BITS = 1 and OUT_BITS = 4) with
// a 4x4 grid of 4x4-pixel cells, and compares the published grids, pulses,
// frame counter and frame-end latency against hand-computed values.
// ---------------------------------------------------------------------------
module tb_video_tile_sampler;

  localparam int DW = 10;
  localparam int XB = 11;
  localparam int YB = 10;
  localparam int IMG_W = 32;
  localparam int IMG_H = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_frame, in_href;
  logic [DW-1:0] in_data;
  logic          cfg_mode;
  logic [DW-1:0] cfg_threshold;
  logic [XB-1:0] cfg_origin_x;
  logic [YB-1:0] cfg_origin_y;

  logic [15:0]   cells1;
  logic [63:0]   cells4;
  logic          valid1, drop1, valid4, drop4;
  logic [15:0]   count1, count4;

  video_tile_sampler #(
    .DATA_WIDTH(DW), .X_BITS(XB), .Y_BITS(YB), .TILE_W(4), .TILE_H(4),
    .CELL_SHIFT(2), .OUT_BITS(1)
  ) dut1 (
    .clk(clk), .reset(reset), .in_frame(in_frame), .in_href(in_href),
    .in_data(in_data), .cfg_mode(cfg_mode), .cfg_threshold(cfg_threshold),
    .cfg_origin_x(cfg_origin_x), .cfg_origin_y(cfg_origin_y),
    .out_cells(cells1), .out_valid(valid1), .out_drop(drop1),
    .out_frame_count(count1)
  );

  video_tile_sampler #(
    .DATA_WIDTH(DW), .X_BITS(XB), .Y_BITS(YB), .TILE_W(4), .TILE_H(4),
    .CELL_SHIFT(2), .OUT_BITS(4)
  ) dut4 (
    .clk(clk), .reset(reset), .in_frame(in_frame), .in_href(in_href),
    .in_data(in_data), .cfg_mode(cfg_mode), .cfg_threshold(cfg_threshold),
    .cfg_origin_x(cfg_origin_x), .cfg_origin_y(cfg_origin_y),
    .out_cells(cells4), .out_valid(valid4), .out_drop(drop4),
    .out_frame_count(count4)
  );

  always #5 clk = ~clk;

  // Pulse-cycle counters, sampled away from the active edge.
  int v1_cnt = 0, d1_cnt = 0, v4_cnt = 0, d4_cnt = 0;
  always @(negedge clk) begin
    if (valid1) v1_cnt++;
    if (drop1)  d1_cnt++;
    if (valid4) v4_cnt++;
    if (drop4)  d4_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int pat, input int x, input int y);
    case (pat)
      0:       return ((x % 4) == 0 && (y % 4) == 0) ? DW'(600) : DW'(0);
      1:       return (x >= 8 && x < 12 && y >= 4 && y < 8) ? DW'(520) : DW'(500);
      2:       return DW'('h3A5);
      default: return DW'(600);
    endcase
  endfunction

  // One frame; in_frame is left low at the end, at posedge + 1.
  task automatic run_frame(input logic mode, input int thr, input int ox, input int oy,
                           input int pat, input int rst_line, input int chg_line,
                           input int chg_thr);
    cfg_mode      = mode;
    cfg_threshold = DW'(thr);
    cfg_origin_x  = XB'(ox);
    cfg_origin_y  = YB'(oy);
    in_frame      = 1'b1;
    repeat (4) cyc();
    for (int y = 0; y < IMG_H; y++) begin
      if (y == rst_line) begin
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
      end
      if (y == chg_line) cfg_threshold = DW'(chg_thr);
      for (int x = 0; x < IMG_W; x++) begin
        in_href = 1'b1;
        in_data = pix(pat, x, y);
        cyc();
      end
      in_href = 1'b0;
      in_data = '0;
      repeat (4) cyc();
    end
    in_frame = 1'b0;
  endtask

  // Clocks until the first out_valid/out_drop after in_frame fell (0 = timeout).
  task automatic wait_end(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid1 || drop1) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
    repeat (4) cyc();
  endtask

  typedef struct {
    string       name;
    logic        mode;
    int          thr;
    int          ox;
    int          oy;
    int          pat;
    logic        exp_pub;
    logic [15:0] exp1;
    logic [63:0] exp4;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;
    int v1s, d1s, v4s, d4s;

    vecs[0] = '{"point_b1",  1'b0, 512,  0, 0,  0, 1'b1, 16'hFFFF, 64'h9999_9999_9999_9999, 1};
    vecs[1] = '{"avg_cell",  1'b1, 512,  0, 0,  1, 1'b1, 16'h0040, 64'h7777_7777_7877_7777, 2};
    vecs[2] = '{"avg_b4",    1'b1, 512,  0, 0,  2, 1'b1, 16'hFFFF, 64'hEEEE_EEEE_EEEE_EEEE, 3};
    vecs[3] = '{"truncated", 1'b1, 1000, 0, 10, 3, 1'b0, 16'hFFFF, 64'hEEEE_EEEE_EEEE_EEEE, 3};

    reset         = 1'b1;
    in_frame      = 1'b0;
    in_href       = 1'b0;
    in_data       = '0;
    cfg_mode      = 1'b0;
    cfg_threshold = '0;
    cfg_origin_x  = '0;
    cfg_origin_y  = '0;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    check("reset_cells1", cells1, 16'h0);
    check("reset_cells4", cells4, 64'h0);
    check("reset_valid",  {valid1, valid4}, 2'b00);
    check("reset_drop",   {drop1, drop4}, 2'b00);
    check("reset_count",  {count1, count4}, 32'h0);
    cyc();
    repeat (4) cyc();

    for (int i = 0; i < 4; i++) begin
      v1s = v1_cnt; d1s = d1_cnt; v4s = v4_cnt; d4s = d4_cnt;
      run_frame(vecs[i].mode, vecs[i].thr, vecs[i].ox, vecs[i].oy, vecs[i].pat, -1, -1, 0);
      wait_end(lat);
      check({vecs[i].name, "_latency"}, lat, 3);
      check({vecs[i].name, "_valid1"}, v1_cnt - v1s, vecs[i].exp_pub ? 1 : 0);
      check({vecs[i].name, "_drop1"},  d1_cnt - d1s, vecs[i].exp_pub ? 0 : 1);
      check({vecs[i].name, "_valid4"}, v4_cnt - v4s, vecs[i].exp_pub ? 1 : 0);
      check({vecs[i].name, "_drop4"},  d4_cnt - d4s, vecs[i].exp_pub ? 0 : 1);
      check({vecs[i].name, "_cells1"}, cells1, vecs[i].exp1);
      check({vecs[i].name, "_cells4"}, cells4, vecs[i].exp4);
      check({vecs[i].name, "_count1"}, count1, vecs[i].exp_cnt);
      check({vecs[i].name, "_count4"}, count4, vecs[i].exp_cnt);
    end

    // Reset at line 8: the aborted frame must produce no pulse at all.
    v1s = v1_cnt; d1s = d1_cnt;
    run_frame(1'b0, 512, 0, 0, 0, 8, -1, 0);
    repeat (20) cyc();
    check("rst_abort_pulses", (v1_cnt - v1s) + (d1_cnt - d1s), 0);
    check("rst_abort_count",  count1, 16'd0);
    check("rst_abort_cells",  cells1, 16'h0);
    v1s = v1_cnt;
    run_frame(1'b0, 512, 0, 0, 0, -1, -1, 0);
    wait_end(lat);
    check("rst_next_latency", lat, 3);
    check("rst_next_valid",   v1_cnt - v1s, 1);
    check("rst_next_cells",   cells1, 16'hFFFF);
    check("rst_next_count",   count1, 16'd1);

    // Threshold drops to 0 at line 5: this frame keeps 512, the next uses 0.
    run_frame(1'b1, 512, 0, 0, 1, -1, 5, 0);
    wait_end(lat);
    check("cfg_hold_cells1", cells1, 16'h0040);
    check("cfg_hold_cells4", cells4, 64'h7777_7777_7877_7777);
    check("cfg_hold_count",  count1, 16'd2);
    run_frame(1'b1, 0, 0, 0, 1, -1, -1, 0);
    wait_end(lat);
    check("cfg_next_cells1", cells1, 16'hFFFF);
    check("cfg_next_cells4", cells4, 64'h7777_7777_7877_7777);
    check("cfg_next_count",  count4, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
